// File: rtl/eth_phy_rx_block_sync.sv
// 64b/66b receive block synchroniser: sync-header lock FSM with gearbox bitslip,
// BER monitor, saturating invalid-header counter and a one-cycle data pipeline.
module eth_phy_rx_block_sync #(
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned HDR_WIDTH           = 2,
    parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
    parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
    parameter int unsigned SH_LOCK_COUNT       = 64,
    parameter int unsigned SH_INVALID_MAX      = 16,
    parameter int unsigned COUNT_125US         = 19531,
    parameter int unsigned BER_THRESHOLD       = 16,
    parameter int unsigned ERR_COUNT_WIDTH     = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]       serdes_rx_hdr,
    input  logic                       serdes_rx_hdr_valid,
    output logic                       serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0]      rx_data,
    output logic [HDR_WIDTH-1:0]       rx_hdr,
    output logic                       rx_valid,
    output logic                       rx_block_lock,
    output logic                       rx_high_ber,
    output logic                       rx_status,
    output logic [ERR_COUNT_WIDTH-1:0] rx_error_count,
    input  logic                       rx_error_count_clr
);

    localparam int unsigned SH_CW       = $clog2(SH_LOCK_COUNT);
    localparam int unsigned INV_CW      = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned SLIP_CYCLES = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
    localparam int unsigned SLIP_CW     = $clog2(SLIP_CYCLES + 1);
    localparam int unsigned TMR_CW      = $clog2(COUNT_125US + 1);
    localparam int unsigned BER_CW      = $clog2(BER_THRESHOLD + 1);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCK   = 2'd1,
        ST_SLIP   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [SH_CW-1:0]           sh_cnt_q, sh_cnt_d;
    logic [INV_CW-1:0]          inv_cnt_q, inv_cnt_d;
    logic [SLIP_CW-1:0]         slip_cnt_q, slip_cnt_d;
    logic                       bitslip_d;
    logic                       block_lock_d;
    logic [TMR_CW-1:0]          ber_tmr_q, ber_tmr_d;
    logic [BER_CW-1:0]          ber_cnt_q, ber_cnt_d, ber_base;
    logic                       ber_wrap;
    logic                       high_ber_d;
    logic                       err_inc, err_sat;
    logic [ERR_COUNT_WIDTH-1:0] err_d;
    logic                       rst_sync_n;
    logic                       hdr_beat, hdr_ok, hdr_bad, sh_last;

    // Reset asserts asynchronously, releases on the first clock edge after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_n <= 1'b0;
        else        rst_sync_n <= 1'b1;
    end

    assign hdr_beat = serdes_rx_hdr_valid;
    assign hdr_ok   = serdes_rx_hdr[1] ^ serdes_rx_hdr[0];
    assign hdr_bad  = hdr_beat & ~hdr_ok;
    assign sh_last  = (sh_cnt_q == SH_CW'(SH_LOCK_COUNT - 1));

    // Lock FSM next state and counters
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        slip_cnt_d = slip_cnt_q;
        unique case (state_q)
            ST_UNLOCK: begin
                if (hdr_beat) begin
                    if (!hdr_ok) begin
                        state_d    = ST_SLIP;
                        sh_cnt_d   = '0;
                        inv_cnt_d  = '0;
                        slip_cnt_d = '0;
                    end else if (sh_last) begin
                        state_d   = ST_LOCK;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_CW'(1);
                    end
                end
            end
            ST_LOCK: begin
                if (hdr_beat) begin
                    if (!hdr_ok && (inv_cnt_q == INV_CW'(SH_INVALID_MAX - 1))) begin
                        state_d    = ST_SLIP;
                        sh_cnt_d   = '0;
                        inv_cnt_d  = '0;
                        slip_cnt_d = '0;
                    end else if (sh_last) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_CW'(1);
                        if (!hdr_ok) inv_cnt_d = inv_cnt_q + INV_CW'(1);
                    end
                end
            end
            ST_SLIP: begin
                if (slip_cnt_q == SLIP_CW'(SLIP_CYCLES - 1)) begin
                    state_d    = ST_UNLOCK;
                    sh_cnt_d   = '0;
                    slip_cnt_d = '0;
                end else begin
                    slip_cnt_d = slip_cnt_q + SLIP_CW'(1);
                end
            end
            default: begin
                state_d    = ST_UNLOCK;
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                slip_cnt_d = '0;
            end
        endcase
        bitslip_d    = (state_d == ST_SLIP) && (slip_cnt_d < SLIP_CW'(BITSLIP_HIGH_CYCLES));
        block_lock_d = (state_q == ST_LOCK) && (state_d == ST_LOCK);
    end

    // BER window: counts invalid beats per timer period, only while locked
    always_comb begin
        ber_tmr_d  = '0;
        ber_cnt_d  = '0;
        ber_base   = '0;
        ber_wrap   = 1'b0;
        high_ber_d = rx_high_ber;
        if (rx_block_lock) begin
            ber_wrap  = (ber_tmr_q == TMR_CW'(COUNT_125US - 1));
            ber_tmr_d = ber_wrap ? '0 : ber_tmr_q + TMR_CW'(1);
            ber_base  = ber_wrap ? '0 : ber_cnt_q;
            if (ber_wrap && (ber_cnt_q < BER_CW'(BER_THRESHOLD))) high_ber_d = 1'b0;
            ber_cnt_d = ber_base;
            if (hdr_bad && (ber_base < BER_CW'(BER_THRESHOLD))) begin
                ber_cnt_d = ber_base + BER_CW'(1);
                if (ber_base == BER_CW'(BER_THRESHOLD - 1)) high_ber_d = 1'b1;
            end
        end
    end

    // Invalid-header counter: clear wins over the old value but not over this beat
    always_comb begin
        err_inc = (state_q == ST_LOCK) && hdr_bad;
        err_sat = &rx_error_count;
        err_d   = rx_error_count;
        if (rx_error_count_clr)      err_d = ERR_COUNT_WIDTH'(err_inc);
        else if (err_inc && !err_sat) err_d = rx_error_count + ERR_COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q           <= ST_UNLOCK;
            sh_cnt_q          <= '0;
            inv_cnt_q         <= '0;
            slip_cnt_q        <= '0;
            serdes_rx_bitslip <= 1'b0;
            rx_block_lock     <= 1'b0;
            ber_tmr_q         <= '0;
            ber_cnt_q         <= '0;
            rx_high_ber       <= 1'b0;
            rx_status         <= 1'b0;
            rx_error_count    <= '0;
            rx_data           <= '0;
            rx_hdr            <= '0;
            rx_valid          <= 1'b0;
        end else begin
            state_q           <= state_d;
            sh_cnt_q          <= sh_cnt_d;
            inv_cnt_q         <= inv_cnt_d;
            slip_cnt_q        <= slip_cnt_d;
            serdes_rx_bitslip <= bitslip_d;
            rx_block_lock     <= block_lock_d;
            ber_tmr_q         <= ber_tmr_d;
            ber_cnt_q         <= ber_cnt_d;
            rx_high_ber       <= high_ber_d;
            rx_status         <= rx_block_lock & ~rx_high_ber;
            rx_error_count    <= err_d;
            rx_data           <= serdes_rx_data;
            rx_hdr            <= serdes_rx_hdr;
            rx_valid          <= serdes_rx_hdr_valid;
        end
    end

endmodule

// File: tb/tb_eth_phy_rx_block_sync.sv
// Scoreboard bench for eth_phy_rx_block_sync: randomized header streams checked
// against a beat-level behavioural model of lock, slip, BER and error counting.
module tb_eth_phy_rx_block_sync;

    localparam int unsigned DW     = 32;
    localparam int unsigned EW     = 3;
    localparam int unsigned C125   = 100;
    localparam int unsigned THR    = 16;
    localparam int unsigned SLC    = 64;
    localparam int unsigned INVMAX = 16;
    localparam int unsigned BH     = 1;
    localparam int unsigned BL     = 8;

    localparam int HUNT = 0, LOCKED = 1, SLIPPING = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] serdes_rx_data = '0;
    logic [1:0]    serdes_rx_hdr = '0;
    logic          serdes_rx_hdr_valid = 1'b0;
    logic          serdes_rx_bitslip;
    logic [DW-1:0] rx_data;
    logic [1:0]    rx_hdr;
    logic          rx_valid, rx_block_lock, rx_high_ber, rx_status;
    logic [EW-1:0] rx_error_count;
    logic          rx_error_count_clr = 1'b0;

    eth_phy_rx_block_sync #(
        .DATA_WIDTH(DW), .HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(BH), .BITSLIP_LOW_CYCLES(BL),
        .SH_LOCK_COUNT(SLC), .SH_INVALID_MAX(INVMAX), .COUNT_125US(C125),
        .BER_THRESHOLD(THR), .ERR_COUNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .serdes_rx_data(serdes_rx_data), .serdes_rx_hdr(serdes_rx_hdr),
        .serdes_rx_hdr_valid(serdes_rx_hdr_valid), .serdes_rx_bitslip(serdes_rx_bitslip),
        .rx_data(rx_data), .rx_hdr(rx_hdr), .rx_valid(rx_valid),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
        .rx_error_count(rx_error_count), .rx_error_count_clr(rx_error_count_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [DW-1:0] data;
        logic [1:0]    hdr;
        logic          valid, bitslip, lock, hber, status;
        logic [EW-1:0] err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state (values before the next clock edge)
    bit            m_synced;
    int            m_mode, m_run, m_win, m_bad, m_age, m_tmr, m_ber, m_err;
    bit            e_bitslip, e_lock, e_hber, e_status, e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_hdr;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    endtask

    // Monitor: compare every expectation whose clock edge has already happened
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].edge_no <= edge_cnt) begin
            mon_e = sbq.pop_front();
            chk("rx_data",           64'(rx_data),           64'(mon_e.data));
            chk("rx_hdr",            64'(rx_hdr),            64'(mon_e.hdr));
            chk("rx_valid",          64'(rx_valid),          64'(mon_e.valid));
            chk("serdes_rx_bitslip", 64'(serdes_rx_bitslip), 64'(mon_e.bitslip));
            chk("rx_block_lock",     64'(rx_block_lock),     64'(mon_e.lock));
            chk("rx_high_ber",       64'(rx_high_ber),       64'(mon_e.hber));
            chk("rx_status",         64'(rx_status),         64'(mon_e.status));
            chk("rx_error_count",    64'(rx_error_count),    64'(mon_e.err));
        end
    end

    task automatic model_reset();
        m_synced = 0; m_mode = HUNT; m_run = 0; m_win = 0; m_bad = 0; m_age = 0;
        m_tmr = 0; m_ber = 0; m_err = 0;
        e_bitslip = 0; e_lock = 0; e_hber = 0; e_status = 0; e_valid = 0;
        e_data = '0; e_hdr = '0;
    endtask

    // One clock edge of the behavioural model
    task automatic model_step(input logic [1:0] hdr, input logic hv, input logic [DW-1:0] d,
                              input logic clr);
        bit bad;
        int inc;
        if (!m_synced) begin
            m_synced = 1;
            return;
        end
        bad      = hv && (hdr == 2'b00 || hdr == 2'b11);
        e_status = e_lock && !e_hber;
        inc      = (m_mode == LOCKED && bad) ? 1 : 0;
        if (clr) m_err = inc;
        else     m_err = (m_err + inc > (1 << EW) - 1) ? (1 << EW) - 1 : m_err + inc;
        if (e_lock) begin
            if (m_tmr == int'(C125) - 1) begin
                m_tmr = 0;
                if (m_ber < int'(THR)) e_hber = 0;
                m_ber = 0;
            end else begin
                m_tmr++;
            end
            if (bad && m_ber < int'(THR)) begin
                m_ber++;
                if (m_ber == int'(THR)) e_hber = 1;
            end
        end else begin
            m_tmr = 0;
            m_ber = 0;
        end
        case (m_mode)
            HUNT: if (hv) begin
                if (bad) begin
                    m_mode = SLIPPING; m_age = 0;
                end else begin
                    m_run++;
                    if (m_run == int'(SLC)) begin m_mode = LOCKED; m_win = 0; m_bad = 0; end
                end
            end
            LOCKED: begin
                if (hv) begin
                    m_win++;
                    if (bad) m_bad++;
                    if (m_bad == int'(INVMAX)) begin m_mode = SLIPPING; m_age = 0; end
                    else if (m_win == int'(SLC)) begin m_win = 0; m_bad = 0; end
                end
                e_lock = (m_mode == LOCKED);
            end
            default: begin
                m_age++;
                if (m_age == int'(BH + BL)) begin m_mode = HUNT; m_run = 0; end
            end
        endcase
        e_bitslip = (m_mode == SLIPPING) && (m_age < int'(BH));
        e_data = d; e_hdr = hdr; e_valid = hv;
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    // Drive one cycle of stimulus and queue the response expected after the next edge
    task automatic cycle(input logic [1:0] hdr, input logic hv, input logic clr);
        exp_t x;
        serdes_rx_data      = DW'($urandom);
        serdes_rx_hdr       = hdr;
        serdes_rx_hdr_valid = hv;
        rx_error_count_clr  = clr;
        model_step(hdr, hv, serdes_rx_data, clr);
        x.edge_no = edge_cnt + 1;
        x.data = e_data; x.hdr = e_hdr; x.valid = e_valid; x.bitslip = e_bitslip;
        x.lock = e_lock; x.hber = e_hber; x.status = e_status; x.err = EW'(m_err);
        sbq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int tries = 0;
        while (sbq.size() > 0 && tries < 8) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
    endtask

    // Asynchronous reset: outputs must drop without waiting for a clock edge
    task automatic do_reset(input int hold);
        drain();
        rst_n = 1'b0;
        serdes_rx_hdr_valid = 1'b0;
        rx_error_count_clr  = 1'b0;
        #1;
        chk("rst_bitslip", 64'(serdes_rx_bitslip), 64'd0);
        chk("rst_lock",    64'(rx_block_lock),     64'd0);
        chk("rst_err",     64'(rx_error_count),    64'd0);
        chk("rst_valid",   64'(rx_valid),          64'd0);
        model_reset();
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sel;
        int          cnt;
        bit          is_bad;
        model_reset();
        #2;
        do_reset(3);

        // Clean alternating headers: lock without any slip
        for (int i = 0; i < 70; i++) cycle((i % 2) ? 2'b10 : 2'b01, 1'b1, 1'b0);

        // Align to a lock window, then 15 invalid (held) and 16 invalid (drop)
        for (int i = 0; i < 64 && m_win != 0; i++) cycle(good_hdr(), 1'b1, 1'b0);
        for (int w = 0; w < 2; w++) begin
            sel = '0; cnt = 0;
            for (int g = 0; g < 1000 && cnt < 15 + w; g++) begin
                int p = $urandom_range(0, 63);
                if (!sel[p]) begin sel[p] = 1'b1; cnt++; end
            end
            for (int i = 0; i < 64; i++) cycle(sel[i] ? bad_hdr() : good_hdr(), 1'b1, 1'b0);
        end

        // Relock, then 16 invalid spread over two lock windows inside one BER window
        for (int i = 0; i < 1000 && !(e_lock && m_win == 0 && m_tmr <= 33); i++)
            cycle(good_hdr(), 1'b1, 1'b0);
        sel = '0; cnt = 0;
        for (int g = 0; g < 1000 && cnt < 14; g++) begin
            int p = $urandom_range(0, 39);
            if (!sel[p]) begin sel[p] = 1'b1; cnt++; end
        end
        sel[64] = 1'b1;
        sel[65] = 1'b1;
        for (int i = 0; i < 66; i++) cycle(sel[i] ? bad_hdr() : good_hdr(), 1'b1, 1'b0);
        for (int i = 0; i < 220; i++) cycle(good_hdr(), 1'b1, 1'b0);

        // Error counter: clear, saturate, clear with increment, clear alone
        cycle(good_hdr(), 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cycle(bad_hdr(), 1'b1, 1'b0);
        cycle(bad_hdr(), 1'b1, 1'b1);
        cycle(good_hdr(), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(good_hdr(), 1'b1, 1'b0);

        // 32-bit gearbox pattern: invalid headers on qualifier-low cycles are ignored
        do_reset(2);
        for (int i = 0; i < 140; i++) begin
            is_bad = (i % 2) == 0;
            cycle(is_bad ? bad_hdr() : good_hdr(), logic'(!is_bad), 1'b0);
        end

        // Random stream with sporadic invalid headers, gaps and clears
        for (int i = 0; i < 400; i++) begin
            is_bad = ($urandom_range(0, 11) == 0);
            cycle(is_bad ? bad_hdr() : good_hdr(), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 15) == 0));
        end

        // Reset during the bitslip high phase, then relock from scratch
        do_reset(2);
        cycle(good_hdr(), 1'b1, 1'b0);
        cycle(bad_hdr(), 1'b1, 1'b0);
        do_reset(2);
        for (int i = 0; i < 70; i++) cycle(good_hdr(), 1'b1, 1'b0);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_phy_rx_block_sync.md
ETH_PHY_RX_BLOCK_SYNC -- requirements
Module: eth_phy_rx_block_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 64; payload width per beat, legal values 32 or 64.
REQ-002 Parameter HDR_WIDTH, default 2; sync header width, fixed at 2.
REQ-003 Parameter BITSLIP_HIGH_CYCLES, default 1; cycles that serdes_rx_bitslip is held high per slip, range 1..255.
REQ-004 Parameter BITSLIP_LOW_CYCLES, default 8; settle cycles after a slip, range 1..255, during which headers are ignored.
REQ-005 Parameter SH_LOCK_COUNT, default 64; header beats per test window, power of two, range 4..1024.
REQ-006 Parameter SH_INVALID_MAX, default 16; invalid headers per window that cause loss of lock, range 1..SH_LOCK_COUNT.
REQ-007 Parameter COUNT_125US, default 19531; clk cycles per BER window.
REQ-008 Parameter BER_THRESHOLD, default 16; invalid headers per BER window that assert high BER.
REQ-009 Parameter ERR_COUNT_WIDTH, default 7; width of the error counter.
REQ-010 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-011 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-012 Port serdes_rx_data  input  DATA_WIDTH  raw payload from the gearbox.
REQ-013 Port serdes_rx_hdr  input  2  raw sync header.
REQ-014 Port serdes_rx_hdr_valid  input  1  header and data qualifier; tied 1 in 64-bit mode, toggles in 32-bit mode.
REQ-015 Port serdes_rx_bitslip  output  1  slip request to the gearbox.
REQ-016 Port rx_data / rx_hdr / rx_valid  output  DATA_WIDTH / 2 / 1  registered copy of the serdes inputs.
REQ-017 Port rx_block_lock, rx_high_ber, rx_status  output  1 each  status outputs.
REQ-018 Port rx_error_count  output  ERR_COUNT_WIDTH  saturating count of invalid headers.
REQ-019 Port rx_error_count_clr  input  1  synchronous clear pulse for rx_error_count.

Function
REQ-020 A header beat is a cycle with serdes_rx_hdr_valid=1; the header is valid if it is 2'b01 or 2'b10, and invalid if it is 2'b00 or 2'b11.
REQ-021 Data path: rx_data, rx_hdr and rx_valid shall equal the serdes inputs delayed by exactly 1 cycle, independent of lock state.
REQ-022 Lock state machine has three states: UNLOCK, LOCK and SLIP; internal counters are sh_cnt (log2(SH_LOCK_COUNT) bits) and inv_cnt.
REQ-023 UNLOCK behaviour:
- On a valid beat, sh_cnt increments.
- On a valid beat with sh_cnt==SH_LOCK_COUNT-1, the FSM goes to LOCK, the counters clear, and rx_block_lock is set on the next edge.
- On an invalid beat, the FSM goes to SLIP and the counters clear.
REQ-024 LOCK behaviour:
- Every beat increments sh_cnt; an invalid beat also increments inv_cnt.
- If the beat makes inv_cnt reach SH_INVALID_MAX, the FSM goes to SLIP, the counters clear, and rx_block_lock clears on the same edge.
- Otherwise, when sh_cnt==SH_LOCK_COUNT-1, the counters clear and the FSM stays in LOCK.
REQ-025 SLIP behaviour:
- serdes_rx_bitslip is high for exactly BITSLIP_HIGH_CYCLES cycles starting the cycle after entry, then low for BITSLIP_LOW_CYCLES cycles.
- All header beats in SLIP are ignored; the FSM then returns to UNLOCK with sh_cnt=0.
REQ-026 serdes_rx_bitslip shall be low in every state other than SLIP; slips never overlap.
REQ-027 BER timer: it counts 0..COUNT_125US-1 and wraps, and runs only while rx_block_lock=1; otherwise it is held at 0.
REQ-028 BER counter counts invalid beats while locked, saturating at BER_THRESHOLD.
- rx_high_ber is set on the edge where the counter reaches BER_THRESHOLD.
- At timer wrap, the counter clears, and rx_high_ber clears if the counter is below BER_THRESHOLD.
- An invalid beat on the wrap cycle counts toward the new window.
REQ-029 While rx_block_lock=0, the BER counter is 0 and rx_high_ber is held at its last value; it is re-evaluated at the first wrap after relock.
REQ-030 rx_error_count increments by 1 on every invalid beat while in LOCK and saturates at all-ones.
- rx_error_count_clr alone sets it to 0.
- Clear and increment in the same cycle set it to 1.
REQ-031 rx_status shall be registered as rx_block_lock & ~rx_high_ber, lagging those signals by 1 cycle.

Reset
REQ-032 When rst_n=0, all outputs are 0, the FSM is in UNLOCK, and all counters are 0, asynchronously.
REQ-033 Deassertion of rst_n is synchronised internally; the first header evaluated is the one on the second rising edge after deassertion.
REQ-034 Reset asserted mid-SLIP drops serdes_rx_bitslip immediately; no residual settle period follows reset.

Verification
REQ-035 Reset, then 64 consecutive valid headers (01/10 alternating), hdr_valid=1: rx_block_lock=1 on the edge after beat 64, and serdes_rx_bitslip is never asserted.
REQ-036 Locked, then 15 invalid headers inside one 64-beat window: lock is held and rx_error_count=15; in the next window, 16 invalid headers: lock drops on the 16th, bitslip is high for 1 cycle, and 8 settle cycles follow with headers ignored.
REQ-037 DATA_WIDTH=32 with hdr_valid toggling, unlocked, one invalid header on a hdr_valid=0 cycle: it is ignored, and lock is reached after 64 valid beats (128 cycles).
REQ-038 COUNT_125US=100, BER_THRESHOLD=16, locked, 16 invalid headers in window 1 while staying below SH_INVALID_MAX per lock window: rx_high_ber=1 and rx_status=0 the cycle after; a clean window 2 clears rx_high_ber at its wrap.
REQ-039 ERR_COUNT_WIDTH=3, 9 invalid headers while locked: rx_error_count saturates at 7; clr together with an invalid beat gives 1; clr alone gives 0.
REQ-040 rst_n pulsed low during the bitslip high phase: serdes_rx_bitslip=0 immediately, and after release the FSM is in UNLOCK with rx_error_count=0.
